// File: rtl/spi_pkg.sv
// spi_pkg: shared widths and FSM state encoding for the SPI slave bridge.
// No ports; imported by spi_bridge.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 3;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'd0,
        SPI_SHIFT = 2'd1,
        SPI_LOAD  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchroniser with one history flop for edge detection.
// Ports:
//   clk     - sampling clock
//   rst_n   - asynchronous active-low reset (chain and history clear to 0)
//   d_i     - asynchronous input
//   level_o - synchronised level
//   rise_o  - one-cycle pulse on a synchronised 0->1 transition
//   fall_o  - one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= level_o;
        end
    end

endmodule

// File: rtl/spi_bridge.sv
// spi_bridge: SPI mode-0 slave front end; deserialises MOSI bytes and serialises responses on MISO.
// Ports:
//   clk       - peripheral clock, all state on its rising edge
//   rst_n     - asynchronous active-low reset
//   sclk      - SPI clock (CPOL=0/CPHA=0), asynchronous to clk
//   cs_n      - SPI chip select, active-low
//   mosi      - serial data from master
//   miso      - serial data to master, always driven
//   byte_sync - one-cycle pulse when a full byte has been received
//   data_in   - last received byte
//   data_out  - response byte from the decoder
module spi_bridge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  byte_sync,
    output logic [SPI_BYTE_W-1:0] data_in,
    input  logic [SPI_BYTE_W-1:0] data_out
);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_state_e            state_q;
    logic [SPI_CNT_W-1:0]  bit_cnt_q;
    logic [SPI_BYTE_W-1:0] rx_q, tx_q, data_in_q;
    logic                  byte_sync_q;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sclk),
        .level_o(sclk_lvl_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .level_o(cs_lvl_unused),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (mosi),
        .level_o(mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    assign miso      = (state_q != SPI_IDLE) && tx_q[SPI_BYTE_W-1];
    assign byte_sync = byte_sync_q;
    assign data_in   = data_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            data_in_q   <= '0;
            byte_sync_q <= 1'b0;
        end else begin
            byte_sync_q <= 1'b0;
            // Deselect beats everything, including a byte completing in the same cycle.
            if (cs_rise) begin
                state_q   <= SPI_IDLE;
                bit_cnt_q <= '0;
                rx_q      <= '0;
            end else begin
                case (state_q)
                    SPI_IDLE: begin
                        if (cs_fall) begin
                            tx_q    <= data_out;
                            state_q <= SPI_SHIFT;
                        end
                    end
                    SPI_SHIFT: begin
                        if (sclk_rise) begin
                            rx_q      <= {rx_q[SPI_BYTE_W-2:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (&bit_cnt_q) begin
                                data_in_q   <= {rx_q[SPI_BYTE_W-2:0], mosi_s};
                                byte_sync_q <= 1'b1;
                            end
                        end else if (sclk_fall && bit_cnt_q != '0) begin
                            // The fall after the last bit is skipped so a freshly loaded MSB survives.
                            tx_q <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
                        end
                        // Reload one cycle after the strobe: the decoder registers its reply on byte_sync.
                        if (byte_sync_q) state_q <= SPI_LOAD;
                    end
                    SPI_LOAD: begin
                        tx_q    <= data_out;
                        state_q <= SPI_SHIFT;
                    end
                    default: state_q <= SPI_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bridge.sv
// tb_spi_bridge: directed self-checking bench for spi_bridge (SPI master model driving pins).
module tb_spi_bridge;

    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi, miso, byte_sync;
    logic [7:0] data_in, data_out, r;
    int         checks = 0, errors = 0, hi_cnt = 0;

    always #5 clk = ~clk;

    spi_bridge #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .byte_sync(byte_sync),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always @(negedge clk) if (byte_sync === 1'b1) hi_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, input logic [7:0] nxt, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            clks(H);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            clks(H);
            sclk = 1'b0;
            if (i == 0) data_out = nxt;
        end
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        clks(8);
    endtask

    task automatic frame_end();
        clks(H);
        cs_n = 1'b1;
        clks(8);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b0; sclk = 1'b0; mosi = 1'b0; data_out = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            clks(3);
            chk("rst_miso", miso, 1'b0);
            chk("rst_sync", byte_sync, 1'b0);
            chk("rst_din", data_in, 8'h00);
            sclk = 1'b0;
            mosi = ~mosi;
            clks(3);
        end
        rst_n = 1'b1;
        clks(4);
        xfer(8'hFF, 8, 8'h55, r);
        chk("idle_pulses", hi_cnt, 0);
        chk("idle_miso", miso, 1'b0);
        cs_n = 1'b1;
        clks(8);

        data_out = 8'h96;
        frame_start();
        xfer(8'h85, 8, 8'h3C, r);
        chk("b1_miso", r, 8'h96);
        chk("b1_din", data_in, 8'h85);
        chk("b1_pulses", hi_cnt, 1);
        xfer(8'h5A, 8, 8'hFF, r);
        chk("b2_miso", r, 8'h3C);
        chk("b2_din", data_in, 8'h5A);
        chk("b2_pulses", hi_cnt, 2);
        chk("load_msb", miso, 1'b1);
        frame_end();
        chk("deselect_miso", miso, 1'b0);

        data_out = 8'h00;
        frame_start();
        xfer(8'hFF, 5, 8'h00, r);
        frame_end();
        chk("abort_pulses", hi_cnt, 2);
        chk("abort_din", data_in, 8'h5A);
        data_out = 8'h66;
        frame_start();
        xfer(8'hC1, 8, 8'h00, r);
        frame_end();
        chk("c1_din", data_in, 8'hC1);
        chk("c1_miso", r, 8'h66);
        chk("c1_pulses", hi_cnt, 3);

        data_out = 8'hFF;
        frame_start();
        xfer(8'hE5, 3, 8'hFF, r);
        rst_n = 1'b0;
        clks(2);
        chk("mid_rst_din", data_in, 8'h00);
        chk("mid_rst_miso", miso, 1'b0);
        chk("mid_rst_sync", byte_sync, 1'b0);
        rst_n = 1'b1;
        clks(4);
        xfer(8'h3C, 8, 8'hFF, r);
        chk("post_rst_idle_pulses", hi_cnt, 3);
        chk("post_rst_idle_din", data_in, 8'h00);
        cs_n = 1'b1;
        clks(8);
        data_out = 8'h11;
        frame_start();
        xfer(8'hA7, 8, 8'h00, r);
        frame_end();
        chk("a7_din", data_in, 8'hA7);
        chk("a7_miso", r, 8'h11);
        chk("a7_pulses", hi_cnt, 4);

        data_out = 8'hC3;
        frame_start();
        for (int i = 0; i < 16; i++) begin
            xfer(8'(8'h5A + i * 19), 8, 8'(8'hC3 - (i + 1) * 11), r);
            chk("b2b_miso", r, 8'(8'hC3 - i * 11));
            chk("b2b_din", data_in, 8'(8'h5A + i * 19));
            chk("b2b_pulses", hi_cnt, 5 + i);
        end
        frame_end();
        chk("b2b_total", hi_cnt, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
